// File: rtl/cpsr_flag_update_if.sv
// rtl/cpsr_flag_update_if.sv - issue/writeback/MSR bus between pipeline control and the CPSR writer
//
// Purpose: groups the issue handshake, flag writeback, MSR commit and CPSR status
//          signals of cpsr_flag_update into one bundle.
// Signals:
//   issue_valid, issue_s       issue of an instruction, and whether it sets flags
//   issue_ready                0 = no room to track another flag-setting instruction
//   wb_valid, wb_s             writeback commit, and whether it writes flags
//   wb_mask[3:0], wb_nzcv[3:0] per-flag enable / value, ordered {N,Z,C,V}
//   msr_valid, msr_fields[3:0] MSR commit and byte mask {f,s,x,c}
//   msr_data[31:0]             MSR source operand
//   cpsr[31:0], cpsr_fwd[31:0] registered CPSR and its next-edge value
//   flags_busy, flag_err       writers outstanding / sticky underflow
// Modports: master = pipeline side (drives requests), slave = cpsr_flag_update.

interface cpsr_flag_update_if;
  logic        issue_valid;
  logic        issue_s;
  logic        issue_ready;
  logic        wb_valid;
  logic        wb_s;
  logic [3:0]  wb_mask;
  logic [3:0]  wb_nzcv;
  logic        msr_valid;
  logic [3:0]  msr_fields;
  logic [31:0] msr_data;
  logic [31:0] cpsr;
  logic [31:0] cpsr_fwd;
  logic        flags_busy;
  logic        flag_err;

  modport master (
    output issue_valid, issue_s, wb_valid, wb_s, wb_mask, wb_nzcv,
           msr_valid, msr_fields, msr_data,
    input  issue_ready, cpsr, cpsr_fwd, flags_busy, flag_err
  );

  modport slave (
    input  issue_valid, issue_s, wb_valid, wb_s, wb_mask, wb_nzcv,
           msr_valid, msr_fields, msr_data,
    output issue_ready, cpsr, cpsr_fwd, flags_busy, flag_err
  );
endinterface

// File: rtl/cpsr_flag_update.sv
// rtl/cpsr_flag_update.sv - architectural CPSR owner and condition-flag writer
//
// Purpose: holds the CPSR, commits NZCV writebacks and MSR writes into it, and
//          counts outstanding flag-setting instructions so issue can stall
//          conditional instructions until their flags are final.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous reset, active low
//   bus    cpsr_flag_update_if.slave (issue/wb/msr inputs, cpsr/cpsr_fwd/
//          issue_ready/flags_busy/flag_err outputs)
// Parameters:
//   PEND_W     width of the outstanding flag-writer counter (max 2**PEND_W-1)
//   RESET_CPSR CPSR value at reset
// Configuration macro:
//   CPSR_CTRL_WR_EN  when defined, MSR may write the s, x and c bytes as well;
//                    otherwise only the flags byte is MSR-writable and
//                    cpsr[23:0] stays RESET_CPSR[23:0].

module cpsr_flag_update #(
  parameter int          PEND_W     = 2,
  parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
  input  logic              clk,
  input  logic              rst_n,
  cpsr_flag_update_if.slave bus
);

  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  logic [31:0]       cpsr_q;
  logic [31:0]       cpsr_next;
  logic [PEND_W-1:0] pend_cnt;
  logic [PEND_W-1:0] pend_cnt_next;
  logic              flag_err_q;
  logic              flag_err_next;
  logic              inc;
  logic              dec;
  logic              ready;

  assign ready = (pend_cnt != CNT_MAX);
  // An S-issue that arrives while the counter is full is not tracked.
  assign inc   = bus.issue_valid & bus.issue_s & ready;
  assign dec   = bus.wb_valid & bus.wb_s;

  always_comb begin
    pend_cnt_next = pend_cnt;
    flag_err_next = flag_err_q;
    if (inc && !dec) begin
      pend_cnt_next = pend_cnt + 1'b1;
    end else if (dec && !inc) begin
      if (pend_cnt == '0) begin
        flag_err_next = 1'b1;
      end else begin
        pend_cnt_next = pend_cnt - 1'b1;
      end
    end
  end

  // Flag commit first, then MSR: a set f field therefore overrides the
  // writeback for the whole top byte, while disjoint bytes both apply.
  always_comb begin
    cpsr_next = cpsr_q;
    if (dec) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wb_mask[i]) begin
          cpsr_next[28+i] = bus.wb_nzcv[i];
        end
      end
    end
    if (bus.msr_valid) begin
      if (bus.msr_fields[3]) cpsr_next[31:24] = bus.msr_data[31:24];
`ifdef CPSR_CTRL_WR_EN
      if (bus.msr_fields[2]) cpsr_next[23:16] = bus.msr_data[23:16];
      if (bus.msr_fields[1]) cpsr_next[15:8]  = bus.msr_data[15:8];
      if (bus.msr_fields[0]) cpsr_next[7:0]   = bus.msr_data[7:0];
`endif
    end
  end

`ifndef CPSR_CTRL_WR_EN
  // Low MSR bytes have no destination in this build.
  logic unused_msr_low;
  assign unused_msr_low = ^{bus.msr_fields[2:0], bus.msr_data[23:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr_q     <= RESET_CPSR;
      pend_cnt   <= '0;
      flag_err_q <= 1'b0;
    end else begin
      cpsr_q     <= cpsr_next;
      pend_cnt   <= pend_cnt_next;
      flag_err_q <= flag_err_next;
    end
  end

  assign bus.cpsr        = cpsr_q;
  assign bus.cpsr_fwd    = cpsr_next;
  assign bus.issue_ready = ready;
  assign bus.flags_busy  = (pend_cnt != '0);
  assign bus.flag_err    = flag_err_q;

endmodule
